// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller blocks.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers plus an edge register for SCL and SDA; derives bus edges
// and START/STOP conditions from the synchronised pair.
module i2c_line_sync (
  input  logic clk,
  input  logic srst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] line_in;
  logic [1:0] sync_s;
  logic [1:0] dly_s;

  assign line_in = {sda, scl};

  // Index 0 is SCL, index 1 is SDA; both idle high so flops reset to 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic meta_reg;
    logic sync_reg;
    logic dly_reg;

    always_ff @(posedge clk) begin
      if (srst) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
        dly_reg  <= 1'b1;
      end else begin
        meta_reg <= line_in[gi];
        sync_reg <= meta_reg;
        dly_reg  <= sync_reg;
      end
    end

    assign sync_s[gi] = sync_reg;
    assign dly_s[gi]  = dly_reg;
  end

  assign scl_rise  = sync_s[0] & ~dly_s[0];
  assign scl_fall  = ~sync_s[0] & dly_s[0];
  assign start_det = sync_s[0] & dly_s[1] & ~sync_s[1];
  assign stop_det  = sync_s[0] & ~dly_s[1] & sync_s[1];
  assign sda_s     = sync_s[1];

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: open-drain SDA, no clock stretching, byte-wide receive
// strobe and a one-entry holding register for read data.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    DATA_BITS   = 8,
  parameter int                    SDA_HOLD    = 30
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 I2C_SCL,
  inout  logic                 I2C_SDA,
  input  logic [DATA_BITS-1:0] IDATA,
  input  logic                 IDRDY,
  output logic                 TXEMPTY,
  output logic [DATA_BITS-1:0] ODATA,
  output logic                 ODRDY,
  output logic                 O_RW,
  output logic                 BUSY,
  output logic                 OSTOP,
  output logic                 TXUNDR
);

  localparam int              HOLD_W    = $clog2(SDA_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SDA_HOLD - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (CLK),
    .srst      (RST),
    .scl       (I2C_SCL),
    .sda       (I2C_SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_t state_reg, state_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-2:0] rx_shift_reg, rx_shift_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 sda_low_reg, sda_low_next;
  logic                 pend_reg, pend_next;
  logic                 pend_low_reg, pend_low_next;
  logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [DATA_BITS-1:0] odata_reg, odata_next;
  logic                 odrdy_reg, odrdy_next;
  logic                 orw_reg, orw_next;
  logic                 busy_reg, busy_next;
  logic                 ostop_reg, ostop_next;
  logic                 txundr_reg, txundr_next;
  logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
  logic                 txempty_reg, txempty_next;

  logic                 sched, sched_low, load;
  logic [DATA_BITS-1:0] rx_byte, tx_byte;
  logic                 addr_hit;

  assign rx_byte  = {rx_shift_reg, sda_s};
  assign addr_hit = (rx_byte[DATA_BITS-1:1] == TARGET_ADDR) &&
                    (rx_byte[DATA_BITS-1:1] != '0);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    sda_low_next   = sda_low_reg;
    pend_next      = pend_reg;
    pend_low_next  = pend_low_reg;
    hold_cnt_next  = hold_cnt_reg;
    odata_next     = odata_reg;
    odrdy_next     = 1'b0;
    orw_next       = orw_reg;
    busy_next      = busy_reg;
    ostop_next     = 1'b0;
    txundr_next    = 1'b0;
    hold_data_next = hold_data_reg;
    txempty_next   = txempty_reg;
    sched          = 1'b0;
    sched_low      = 1'b0;
    load           = 1'b0;
    tx_byte        = '1;

    // Apply a scheduled SDA change once the hold time has elapsed.
    if (pend_reg) begin
      if (hold_cnt_reg == '0) begin
        sda_low_next = pend_low_reg;
        pend_next    = 1'b0;
      end else begin
        hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
      end
    end

    if (stop_det || start_det) begin
      state_next   = stop_det ? IDLE : ADDR;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
      pend_next    = 1'b0;
      if (busy_reg) begin
        busy_next  = 1'b0;
        ostop_next = 1'b1;
      end
    end else begin
      unique case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            rx_shift_next = rx_byte[DATA_BITS-2:0];
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next = '0;
              if (addr_hit) begin
                orw_next   = rx_byte[0];
                busy_next  = 1'b1;
                state_next = ADDR_ACK;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end
        // bit_cnt 0: waiting for the last data bit's fall; 1: waiting for the ACK clock's fall.
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_reg == '0) begin
              sched        = 1'b1;
              sched_low    = ~I2C_ACK;
              bit_cnt_next = 4'd1;
            end else begin
              bit_cnt_next = '0;
              if (state_reg == ADDR_ACK && orw_reg) begin
                state_next = TX;
                load       = 1'b1;
              end else begin
                state_next = RX;
                sched      = 1'b1;
              end
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            rx_shift_next = rx_byte[DATA_BITS-2:0];
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST_BIT) begin
              odata_next   = rx_byte;
              odrdy_next   = 1'b1;
              bit_cnt_next = '0;
              state_next   = RX_ACK;
            end
          end
        end
        TX: begin
          if (scl_fall) begin
            sched = 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next = '0;
              state_next   = TX_ACK;
            end else begin
              tx_shift_next = tx_shift_reg << 1;
              sched_low     = ~tx_shift_reg[DATA_BITS-2];
              bit_cnt_next  = bit_cnt_reg + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && bit_cnt_reg == '0) begin
            if (sda_s == I2C_ACK) bit_cnt_next = 4'd1;
            else                  state_next   = WAIT_STOP;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = '0;
            state_next   = TX;
            load         = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A load takes the register contents as they were before any same-cycle IDRDY.
    if (load) begin
      if (!txempty_reg) begin
        tx_byte      = hold_data_reg;
        txempty_next = 1'b1;
      end else begin
        txundr_next = 1'b1;
      end
      tx_shift_next = tx_byte;
      sched         = 1'b1;
      sched_low     = ~tx_byte[DATA_BITS-1];
    end

    if (sched) begin
      pend_next     = 1'b1;
      pend_low_next = sched_low;
      hold_cnt_next = HOLD_INIT;
    end

    if (IDRDY) begin
      hold_data_next = IDATA;
      txempty_next   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      sda_low_reg   <= 1'b0;
      pend_reg      <= 1'b0;
      pend_low_reg  <= 1'b0;
      hold_cnt_reg  <= '0;
      odata_reg     <= '0;
      odrdy_reg     <= 1'b0;
      orw_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      ostop_reg     <= 1'b0;
      txundr_reg    <= 1'b0;
      hold_data_reg <= '0;
      txempty_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      sda_low_reg   <= sda_low_next;
      pend_reg      <= pend_next;
      pend_low_reg  <= pend_low_next;
      hold_cnt_reg  <= hold_cnt_next;
      odata_reg     <= odata_next;
      odrdy_reg     <= odrdy_next;
      orw_reg       <= orw_next;
      busy_reg      <= busy_next;
      ostop_reg     <= ostop_next;
      txundr_reg    <= txundr_next;
      hold_data_reg <= hold_data_next;
      txempty_reg   <= txempty_next;
    end
  end

  // Release immediately while reset is asserted, not one cycle later.
  assign I2C_SDA = (sda_low_reg && !RST) ? 1'b0 : 1'bz;

  assign TXEMPTY = txempty_reg;
  assign ODATA   = odata_reg;
  assign ODRDY   = odrdy_reg;
  assign O_RW    = orw_reg;
  assign BUSY    = busy_reg;
  assign OSTOP   = ostop_reg;
  assign TXUNDR  = txundr_reg;

endmodule
